// File: rtl/group_serial_adder.sv
// group_serial_adder: multi-cycle adder/subtractor that processes GROUP bits
// per clock, LSB slice first, rippling the carry through a register between
// slices. A WIDTH-bit result is ready after WIDTH/GROUP RUN cycles and is
// announced by a one-cycle done pulse.
module group_serial_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c0,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / GROUP;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  // a_reg doubles as the result accumulator: operand bits shift out at the
  // bottom while finished sum slices shift in at the top.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic [GROUP:0]   slice;
  logic [WIDTH-1:0] a_next;
  logic             msb_cin;

  // Add the current low slice of both operands plus the registered carry.
  always_comb begin
    slice = {1'b0, a_reg[GROUP-1:0]} + {1'b0, b_reg[GROUP-1:0]}
          + {{GROUP{1'b0}}, carry};
  end

  // On the final slice the top operand bits sit in the low group, so the
  // carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    msb_cin = a_reg[GROUP-1] ^ b_reg[GROUP-1] ^ slice[GROUP-1];
  end

  generate
    if (GROUP == WIDTH) begin : g_single
      // Whole word in one slice: the accumulator is just the slice sum.
      always_comb a_next = slice[GROUP-1:0];
    end else begin : g_multi
      // Shift the new sum slice in at the top, drop the consumed operand bits.
      always_comb a_next = {slice[GROUP-1:0], a_reg[WIDTH-1:GROUP]};
    end
  endgenerate

  // Status flags decode straight from the state register, so an asynchronous
  // reset clears them in the same instant it clears the state.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Control FSM, operand/carry datapath and registered result.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= x;
            b_reg <= sub ? ~y : y;
            carry <= sub ? 1'b1 : c0;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_next;
          b_reg <= b_reg >> GROUP;
          carry <= slice[GROUP];
          idx   <= idx + IDX_W'(1);
          if (idx == LAST) begin
            s     <= a_next;
            cout  <= slice[GROUP];
            ovf   <= msb_cin ^ slice[GROUP];
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_group_serial_adder.sv
// Testbench for group_serial_adder: a 16/4 instance and an 8/2 instance.
// Expected results come from a plain full-width reference model, are queued
// when a start is driven, and are popped when done is observed.
module tb_group_serial_adder;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [15:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start16, c016, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] x16, y16, s16;
  logic        start8, c08, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  x8, y8, s8;

  int total = 0;
  int bad   = 0;

  exp_t q16[$];
  exp_t q8[$];
  exp_t last16;

  group_serial_adder #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .x(x16), .y(y16), .c0(c016),
    .sub(sub16), .busy(busy16), .done(done16), .s(s16), .cout(cout16),
    .ovf(ovf16)
  );

  group_serial_adder #(.WIDTH(8), .GROUP(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8), .c0(c08),
    .sub(sub8), .busy(busy8), .done(done8), .s(s8), .cout(cout8),
    .ovf(ovf8)
  );

  // Reference: full-width add of A + effective B + effective carry-in.
  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] bv,
                                   input logic cin_raw, input logic sb);
    logic [15:0] b;
    logic        cin;
    logic [16:0] r;
    exp_t        e;
    b     = sb ? ~bv : bv;
    cin   = sb ? 1'b1 : cin_raw;
    r     = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    e.s   = r[15:0];
    e.cout = r[16];
    e.ovf = (a[15] == b[15]) && (r[15] != a[15]);
    return e;
  endfunction

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] bv,
                                  input logic cin_raw, input logic sb);
    logic [7:0] b;
    logic       cin;
    logic [8:0] r;
    exp_t       e;
    b     = sb ? ~bv : bv;
    cin   = sb ? 1'b1 : cin_raw;
    r     = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    e.s   = {8'd0, r[7:0]};
    e.cout = r[8];
    e.ovf = (a[7] == b[7]) && (r[7] != a[7]);
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy16, done16, s16, cout16, ovf16} !== 19'd0) begin
      bad++;
      $display("FAIL reset16: got busy=%b done=%b s=%h cout=%b ovf=%b want all zero",
               busy16, done16, s16, cout16, ovf16);
    end
    total++;
    if ({busy8, done8, s8, cout8, ovf8} !== 11'd0) begin
      bad++;
      $display("FAIL reset8: got busy=%b done=%b s=%h cout=%b ovf=%b want all zero",
               busy8, done8, s8, cout8, ovf8);
    end
    rst = 1'b0;
  endtask

  // One 16-bit operation. Operands are scrambled right after capture; if
  // poke is nonzero a new start with fresh operands is pulsed in that RUN cycle.
  task automatic run16(input logic [15:0] xa, input logic [15:0] ya,
                       input logic ca, input logic sa, input int poke,
                       input string name);
    exp_t e;
    @(negedge clk);
    x16 = xa; y16 = ya; c016 = ca; sub16 = sa; start16 = 1'b1;
    q16.push_back(model16(xa, ya, ca, sa));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start16 = 1'b0;
        x16 = 16'($urandom); y16 = 16'($urandom);
        c016 = 1'($urandom); sub16 = 1'($urandom);
      end
      if (k == poke) begin
        start16 = 1'b1;
        x16 = 16'($urandom); y16 = 16'($urandom);
      end
      if (k == poke + 1) start16 = 1'b0;
      total++;
      if ({busy16, done16} !== 2'b10) begin
        bad++;
        $display("FAIL %s run cycle %0d: got busy=%b done=%b want busy=1 done=0",
                 name, k, busy16, done16);
      end
    end
    @(negedge clk);
    start16 = 1'b0;
    total++;
    if ({busy16, done16} !== 2'b01) begin
      bad++;
      $display("FAIL %s done cycle: got busy=%b done=%b want busy=0 done=1",
               name, busy16, done16);
    end
    total++;
    if (q16.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard: got empty queue want one entry", name);
    end else begin
      e = q16.pop_front();
      last16 = e;
      if ({ovf16, cout16, s16} !== e) begin
        bad++;
        $display("FAIL %s result: got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                 name, s16, cout16, ovf16, e.s, e.cout, e.ovf);
      end
    end
    @(negedge clk);
    total++;
    if ({busy16, done16, ovf16, cout16, s16} !== {2'b00, last16}) begin
      bad++;
      $display("FAIL %s after done: got busy=%b done=%b s=%h want busy=0 done=0 s=%h",
               name, busy16, done16, s16, last16.s);
    end
  endtask

  task automatic test_hold;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      x16 = 16'($urandom); y16 = 16'($urandom);
      c016 = 1'($urandom); sub16 = 1'($urandom);
    end
    total++;
    if ({ovf16, cout16, s16} !== last16 || done16 !== 1'b0) begin
      bad++;
      $display("FAIL hold: got s=%h cout=%b ovf=%b done=%b want s=%h cout=%b ovf=%b done=0",
               s16, cout16, ovf16, done16, last16.s, last16.cout, last16.ovf);
    end
  endtask

  task automatic test_mid_reset;
    int pulses;
    @(negedge clk);
    x16 = 16'h1234; y16 = 16'h4321; c016 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) start16 = 1'b0;
    end
    rst = 1'b1;
    #1;
    total++;
    if ({busy16, done16, s16, cout16, ovf16} !== 19'd0) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b done=%b s=%h cout=%b ovf=%b want all zero",
               busy16, done16, s16, cout16, ovf16);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done16 === 1'b1 || busy16 === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL mid_reset abort: got %0d busy/done cycles want 0", pulses);
    end
  endtask

  task automatic test_start_held8;
    exp_t e;
    @(negedge clk);
    x8 = 8'hFF; y8 = 8'h01; c08 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    q8.push_back(model8(8'hFF, 8'h01, 1'b0, 1'b0));
    for (int op = 0; op < 2; op++) begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (op == 1 && k == 1) start8 = 1'b0;
        total++;
        if ({busy8, done8} !== 2'b10) begin
          bad++;
          $display("FAIL held8 op%0d run cycle %0d: got busy=%b done=%b want busy=1 done=0",
                   op, k, busy8, done8);
        end
      end
      @(negedge clk);
      total++;
      if ({busy8, done8} !== 2'b01) begin
        bad++;
        $display("FAIL held8 op%0d done cycle: got busy=%b done=%b want busy=0 done=1",
                 op, busy8, done8);
      end
      total++;
      if (q8.size() == 0) begin
        bad++;
        $display("FAIL held8 op%0d scoreboard: got empty queue want one entry", op);
      end else begin
        e = q8.pop_front();
        if ({ovf8, cout8, s8} !== {e.ovf, e.cout, e.s[7:0]}) begin
          bad++;
          $display("FAIL held8 op%0d result: got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                   op, s8, cout8, ovf8, e.s[7:0], e.cout, e.ovf);
        end
      end
      if (op == 0) begin
        x8 = 8'h12; y8 = 8'h34; c08 = 1'b0; sub8 = 1'b1;
        q8.push_back(model8(8'h12, 8'h34, 1'b0, 1'b1));
        @(negedge clk);
        total++;
        if ({busy8, done8} !== 2'b00) begin
          bad++;
          $display("FAIL held8 idle gap: got busy=%b done=%b want busy=0 done=0",
                   busy8, done8);
        end
      end
    end
    start8 = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0, "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    start16 = 1'b0; x16 = '0; y16 = '0; c016 = 1'b0; sub16 = 1'b0;
    start8  = 1'b0; x8  = '0; y8  = '0; c08  = 1'b0; sub8  = 1'b0;
    last16 = '0;
    test_reset;
    run16(16'h1A33, 16'hE5EB, 1'b0, 1'b0, 0, "basic_add");
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "signed_ovf");
    run16(16'h0005, 16'h0007, 1'b1, 1'b1, 0, "subtract");
    test_mid_reset;
    run16(16'hABCD, 16'h1111, 1'b1, 1'b0, 0, "after_reset");
    run16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 2, "full_ripple");
    test_hold;
    test_start_held8;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/group_serial_adder.md
GROUP_SERIAL_ADDER -- requirements
Module: group_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter GROUP, default 4, bits added per clock cycle.
REQ-003 SHALL support only GROUP >= 1 with WIDTH an exact multiple of GROUP; N = WIDTH/GROUP.
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  in  1  request a new operation; honoured only in IDLE.
REQ-007 SHALL have port x  in  WIDTH  operand A.
REQ-008 SHALL have port y  in  WIDTH  operand B.
REQ-009 SHALL have port c0  in  1  carry-in; used only when sub=0.
REQ-010 SHALL have port sub  in  1  0 = x+y+c0, 1 = x-y.
REQ-011 SHALL have port busy  out  1  high while in RUN.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port s  out  WIDTH  result, registered.
REQ-014 SHALL have port cout  out  1  carry out of the MSB; for sub=1, 1 means no borrow.
REQ-015 SHALL have port ovf  out  1  two's-complement signed overflow.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 IDLE with start=1 at an edge SHALL capture x, the effective B, and the effective carry-in, clear the group index, and enter RUN.
REQ-018 Effective B and carry-in SHALL be (y, c0) for sub=0 and (~y, 1) for sub=1.
REQ-019 RUN SHALL add one GROUP-bit slice per cycle, LSB slice first, using the carry registered from the previous slice.
REQ-020 RUN SHALL last exactly N cycles, then enter DONE.
REQ-021 On the RUN->DONE edge, s, cout and ovf SHALL be loaded together.
REQ-022 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 Latency SHALL be N+1 edges from the start-sampling edge to the cycle in which done is high.
REQ-025 busy SHALL be 1 exactly during the N RUN cycles.
REQ-026 start SHALL be ignored in RUN and DONE; the operation in flight SHALL be unaffected.
REQ-027 Changes on x, y, c0 and sub after capture SHALL be ignored until the next accepted start.
REQ-028 s, cout and ovf SHALL hold their last values from completion until the next completion or reset.
REQ-029 A start held high continuously SHALL be re-accepted at the first IDLE edge after DONE.
REQ-030 Arithmetic SHALL be modulo 2^WIDTH.
REQ-031 Carry propagation SHALL be correct across all group boundaries, including a full ripple through all N groups.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, busy=0, done=0, s=0, cout=0, ovf=0, and clear all internal operand, carry and index registers.
REQ-033 rst asserted mid-RUN SHALL abort the operation with no done pulse and no output update.
REQ-034 After rst deasserts, the first start SHALL be accepted at the next IDLE edge.

Verification
REQ-035 Bench SHALL cover these scenarios:
- WIDTH=16, GROUP=4: x=0x1A33, y=0xE5EB, c0=0, sub=0, one-cycle start -> busy for 4 cycles, done on the 5th; s=0x001E, cout=1, ovf=0.
- x=0x7FFF, y=0x0001, c0=0, sub=0 -> s=0x8000, cout=0, ovf=1.
- x=0x0005, y=0x0007, sub=1, c0=1 (c0 ignored) -> s=0xFFFE, cout=0, ovf=0.
- x=0xFFFF, y=0x0000, c0=1 (full ripple):
  - s=0x0000, cout=1, ovf=0.
  - Then start pulsed in cycle 2 of RUN with new operands -> ignored; result unchanged.
  - Outputs held after done.
- rst raised in cycle 3 of RUN -> busy=0 immediately, no done pulse, s/cout/ovf=0; next start completes normally.
- WIDTH=8, GROUP=2: x=0xFF, y=0x01, c0=0, start held high -> done after 5 edges; s=0x00, cout=1, ovf=0; second operation starts on the next IDLE edge.
